reset_sequencer: RTL

RESET_SEQUENCER -- requirements
Module: reset_sequencer

---
 rtl/reset_sequencer_if.sv | 38 +++
 rtl/reset_sequencer.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/reset_sequencer_if.sv
// Control and status bundle between the reset sequencer and the logic it
// brings up. The master modport is the sequencer side.
interface reset_sequencer_if #(
    parameter int unsigned MAX_RETRIES = 3
);
    localparam int unsigned RET_W = $clog2(MAX_RETRIES + 1);

    logic             i_locked;
    logic             i_restart;
    logic             o_mmcm_rst;
    logic             o_sys_rst_n;
    logic             o_ready;
    logic             o_fault;
    logic [RET_W-1:0] o_retries;
    logic [2:0]       o_state;

    modport master (
        input  i_locked,
        input  i_restart,
        output o_mmcm_rst,
        output o_sys_rst_n,
        output o_ready,
        output o_fault,
        output o_retries,
        output o_state
    );

    modport slave (
        output i_locked,
        output i_restart,
        input  o_mmcm_rst,
        input  o_sys_rst_n,
        input  o_ready,
        input  o_fault,
        input  o_retries,
        input  o_state
    );
endinterface

// File: rtl/reset_sequencer.sv
// Board-level reset sequencer: pulses the MMCM reset, waits for LOCKED,
// requires a stable lock window, then releases the system reset.
// Optional feature macro: RSTSEQ_LOCK_TIMEOUT_EN enables the per-attempt
// lock timeout, bounded retries and the FAULT state. Without it WAIT_LOCK
// waits forever and o_fault / o_retries stay 0.
module reset_sequencer #(
    parameter int unsigned MMCM_RST_CYCLES     = 8,
    parameter int unsigned SETTLE_CYCLES       = 256,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 100000,
    parameter int unsigned MAX_RETRIES         = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    reset_sequencer_if.master    bus
);

    localparam int unsigned MAX_AB  = (MMCM_RST_CYCLES > SETTLE_CYCLES) ? MMCM_RST_CYCLES : SETTLE_CYCLES;
    localparam int unsigned CNT_MAX = (MAX_AB > LOCK_TIMEOUT_CYCLES) ? MAX_AB : LOCK_TIMEOUT_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;
    localparam int unsigned RET_W   = $clog2(MAX_RETRIES + 1);

    typedef enum logic [2:0] {
        ST_MMCM_RST  = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_SETTLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAULT     = 3'd4
    } state_t;

    logic             r_locked_meta;
    logic             r_locked_s;
    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [RET_W-1:0] r_retries;
    logic [RET_W-1:0] w_retries_nxt;
    logic             r_mmcm_rst;
    logic             r_sys_rst_n;
    logic             r_ready;
    logic             r_fault;

    // Two-flop synchroniser for the asynchronous LOCKED input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_locked_meta <= 1'b0;
            r_locked_s    <= 1'b0;
        end else begin
            r_locked_meta <= bus.i_locked;
            r_locked_s    <= r_locked_meta;
        end
    end

    // Saturating increment so a long wait can never wrap back into range.
    assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);

    // Next-state, counter and retry decisions; restart overrides everything.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = w_cnt_inc;
        w_retries_nxt = r_retries;
        if (bus.i_restart) begin
            w_state_nxt   = ST_MMCM_RST;
            w_cnt_nxt     = '0;
            w_retries_nxt = '0;
        end else begin
            case (r_state)
                ST_MMCM_RST: begin
                    if (r_cnt >= CNT_W'(MMCM_RST_CYCLES - 1)) begin
                        w_state_nxt = ST_WAIT_LOCK;
                        w_cnt_nxt   = '0;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (r_locked_s) begin
                        w_state_nxt = ST_SETTLE;
                        w_cnt_nxt   = '0;
                    end
`ifdef RSTSEQ_LOCK_TIMEOUT_EN
                    else if (r_cnt >= CNT_W'(LOCK_TIMEOUT_CYCLES - 1)) begin
                        w_cnt_nxt = '0;
                        if (r_retries < RET_W'(MAX_RETRIES)) begin
                            w_state_nxt   = ST_MMCM_RST;
                            w_retries_nxt = r_retries + RET_W'(1);
                        end else begin
                            w_state_nxt = ST_FAULT;
                        end
                    end
`endif
                end
                ST_SETTLE: begin
                    if (!r_locked_s) begin
                        w_state_nxt = ST_WAIT_LOCK;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt >= CNT_W'(SETTLE_CYCLES - 1)) begin
                        w_state_nxt   = ST_RUN;
                        w_cnt_nxt     = '0;
                        w_retries_nxt = '0;
                    end
                end
                ST_RUN: begin
                    w_cnt_nxt = '0;
                    if (!r_locked_s) begin
                        w_state_nxt = ST_WAIT_LOCK;
                    end
                end
                ST_FAULT: begin
                    w_cnt_nxt = '0;
                end
                default: begin
                    w_state_nxt = ST_MMCM_RST;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // State register plus outputs decoded from the next state, so every
    // output changes on the same edge as the state it reflects.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_MMCM_RST;
            r_cnt       <= '0;
            r_retries   <= '0;
            r_mmcm_rst  <= 1'b1;
            r_sys_rst_n <= 1'b0;
            r_ready     <= 1'b0;
            r_fault     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_retries   <= w_retries_nxt;
            r_mmcm_rst  <= (w_state_nxt == ST_MMCM_RST) || (w_state_nxt == ST_FAULT);
            r_sys_rst_n <= (w_state_nxt == ST_RUN);
            r_ready     <= (w_state_nxt == ST_RUN);
`ifdef RSTSEQ_LOCK_TIMEOUT_EN
            r_fault     <= (w_state_nxt == ST_FAULT);
`else
            r_fault     <= 1'b0;
`endif
        end
    end

    assign bus.o_mmcm_rst  = r_mmcm_rst;
    assign bus.o_sys_rst_n = r_sys_rst_n;
    assign bus.o_ready     = r_ready;
    assign bus.o_fault     = r_fault;
    assign bus.o_retries   = r_retries;
    assign bus.o_state     = 3'(r_state);

endmodule
